// File: rtl/instr_decode_flags_pkg.sv
// Shared constants for the instruction/flag stage:
// opcodes, condition codes, field positions, flag bit indices.
package instr_decode_flags_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_JAL = 4'hE;
  localparam logic [3:0] OP_J   = 4'hF;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_MI = 3'd3;
  localparam logic [2:0] COND_PL = 3'd4;
  localparam logic [2:0] COND_CS = 3'd5;
  localparam logic [2:0] COND_CC = 3'd6;
  localparam logic [2:0] COND_VS = 3'd7;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int LMC_BIT  = 11;
  localparam int COND_MSB = 10;
  localparam int COND_LSB = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 4;
  localparam int RB_MSB   = 3;
  localparam int RB_LSB   = 0;
  localparam int IMM_MSB  = 7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/instr_decode_flags_if.sv
// Bus between control unit (master) and decode stage (slave).
// Carries fetch data, strobes, ALU flags and decoded outputs.
interface instr_decode_flags_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] MemData;
  logic             IW;
  logic             FU;
  logic [3:0]       ALUFlags;
  logic             ClrCnt;
  logic [3:0]       Op;
  logic             LMC;
  logic             Perform;
  logic [3:0]       RA;
  logic [3:0]       RB;
  logic [WIDTH-1:0] Imm16;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] FetchCnt;
  logic [CNT_W-1:0] SkipCnt;

  modport master (
    output MemData, IW, FU, ALUFlags, ClrCnt,
    input  Op, LMC, Perform, RA, RB, Imm16,
    input  Flags, FetchCnt, SkipCnt
  );

  modport slave (
    input  MemData, IW, FU, ALUFlags, ClrCnt,
    output Op, LMC, Perform, RA, RB, Imm16,
    output Flags, FetchCnt, SkipCnt
  );
endinterface

// File: rtl/instr_decode_flags_cond_eval.sv
// Condition evaluator: cond[2:0] against flags {V,C,N,Z}.
// Ports: cond, flags in; pass out (1 = execute).
import instr_decode_flags_pkg::*;

module cond_eval (
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  always_comb begin
    pass = 1'b1;
    unique case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLAG_Z];
      COND_NE: pass = ~flags[FLAG_Z];
      COND_MI: pass = flags[FLAG_N];
      COND_PL: pass = ~flags[FLAG_N];
      COND_CS: pass = flags[FLAG_C];
      COND_CC: pass = ~flags[FLAG_C];
      COND_VS: pass = flags[FLAG_V];
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_decode_flags.sv
// Instruction register, flag register, condition check, counters.
// Ports: CLK, RESET (async active-low), bus (slave side).
import instr_decode_flags_pkg::*;

module instr_decode_flags #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input logic              CLK,
  input logic              RESET,
  instr_decode_flags_if.slave bus
);
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] word;
  logic [3:0]       flags;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] skip_cnt;
  logic [2:0]       cond;
  logic             perform;

  // Bypass lets the control unit decode in the IR-write cycle.
  assign word = bus.IW ? bus.MemData : ir;
  assign cond = word[COND_MSB:COND_LSB];

  cond_eval u_cond (
    .cond  (cond),
    .flags (flags),
    .pass  (perform)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ir    <= '0;
      flags <= '0;
    end else begin
      if (bus.IW) ir <= bus.MemData;
      if (bus.FU) flags <= bus.ALUFlags;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_cnt <= '0;
      skip_cnt  <= '0;
    end else if (bus.ClrCnt) begin
      fetch_cnt <= '0;
      skip_cnt  <= '0;
    end else if (bus.IW) begin
      fetch_cnt <= fetch_cnt + 1'b1;
      if (!perform) skip_cnt <= skip_cnt + 1'b1;
    end
  end

  assign bus.Op       = word[OP_MSB:OP_LSB];
  assign bus.LMC      = word[LMC_BIT];
  assign bus.Perform  = perform;
  assign bus.RA       = word[RA_MSB:RA_LSB];
  assign bus.RB       = word[RB_MSB:RB_LSB];
  assign bus.Imm16    = {{(WIDTH-8){word[IMM_MSB]}},
                         word[IMM_MSB:0]};
  assign bus.Flags    = flags;
  assign bus.FetchCnt = fetch_cnt;
  assign bus.SkipCnt  = skip_cnt;
endmodule

// File: doc/instr_decode_flags.md
Name: instr_decode_flags

Overview:
- Instruction-register and condition stage directly upstream of the multi-cycle control unit.
- Captures the fetched 16-bit instruction on IW and supplies Op, LMC and Perform to the control FSM.
- Holds the architectural flag register, updated on FU, and evaluates each instruction's condition code against it.
- Exposes operand fields to the datapath and keeps fetch/skip performance counters.

Parameters:
- WIDTH, 16: instruction and data word width.
- CNT_W, 16: width of the fetch and skip counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- MemData  in  WIDTH  memory read data; holds the instruction during the cycle IW is high.
- IW  in  1  instruction write strobe from the control unit.
- FU  in  1  flag update strobe from the control unit.
- ALUFlags  in  4  ALU result flags {V,C,N,Z}.
- ClrCnt  in  1  synchronous clear of both counters.
- Op  out  4  opcode to the control unit.
- LMC  out  1  memory-operand flag to the control unit.
- Perform  out  1  condition passed.
- RA  out  4  register field A.
- RB  out  4  register field B / imm4.
- Imm16  out  WIDTH  sign-extended imm8.
- Flags  out  4  flag register {V,C,N,Z}.
- FetchCnt  out  CNT_W  instructions fetched.
- SkipCnt  out  CNT_W  instructions skipped.

Behaviour:
- Instruction format:
  - [15:12] opcode
  - [11] LMC
  - [10:8] cond
  - [7:4] RA
  - [3:0] RB
  - imm8 = [7:0]
- IR register:
  - Loads MemData at the rising edge where IW=1; otherwise holds.
  - Reset value 0x0000.
- Decode source mux (IW bypass):
  - While IW=1, all decoded outputs (Op, LMC, cond, RA, RB, Imm16, Perform) derive from MemData, not IR.
  - This gives the control unit a valid Op/LMC/Perform in its decode state, the same cycle the IR is written.
  - While IW=0, all decoded outputs derive from IR.
  - The mux is combinational: zero-cycle latency from MemData to Op when IW=1.
- Imm16 = {8{imm8[7]}, imm8}.
- Flag register:
  - Loads ALUFlags on the rising edge where FU=1.
  - Reset value 4'b0000.
  - Flags output = register contents.
- Condition evaluation (cond -> Perform, using the registered Flags):
  - 000 -> 1 (always)
  - 001 -> Z
  - 010 -> ~Z
  - 011 -> N
  - 100 -> ~N
  - 101 -> C
  - 110 -> ~C
  - 111 -> V
- Simultaneous IW and FU:
  - Both registers update.
  - Perform in that cycle uses the pre-update flags; there is no flag bypass.
- Counters:
  - FetchCnt increments on every edge with IW=1.
  - SkipCnt increments on every edge with IW=1 and Perform=0.
  - Both wrap modulo 2^CNT_W with no saturation.
  - ClrCnt=1 zeroes both counters, taking priority over increment.
  - Reset value 0.
- Reset mid-operation:
  - RESET=0 immediately forces IR, Flags and both counters to 0, independent of CLK.
  - With IW=0 the outputs then read Op=ADD (0000), LMC=0, Perform=1.
  - The first rising edge after RESET deasserts operates normally.
- Outputs reset to: Op=0, LMC=0, Perform=1, RA=0, RB=0, Imm16=0, Flags=0, FetchCnt=0, SkipCnt=0.
  - This holds while IW=0; with IW=1 the decoded outputs follow MemData.

Decomposition:
- Shared package contents:
  - Opcode constants (ADD..J, 4-bit).
  - Condition-code constants (COND_AL, COND_EQ, COND_NE, COND_MI, COND_PL, COND_CS, COND_CC, COND_VS).
  - Instruction field bit positions.
  - Flag bit indices (Z=0, N=1, C=2, V=3).
- One sub-module: cond_eval (combinational; cond[2:0] and flags[3:0] -> pass).
- Registers and counters stay in the top block.

Test Plan:
- Reset then bypass: RESET=0 then 1; IW=1 with MemData=0x2915 -> same cycle Op=0010, LMC=1, cond=001, Perform=0 (Z=0), RA=1, RB=5; after the edge, IW=0 still shows Op=0010; FetchCnt=1, SkipCnt=1.
- Flag update then condition: FU=1 with ALUFlags=4'b0001; then IW=1 with MemData=0x0100 (cond=001) -> Perform=1; MemData=0x0200 (cond=010) -> Perform=0.
- Simultaneous IW and FU: Flags=0, IW=1 and FU=1 with ALUFlags=0001, cond=001 -> Perform=0 in that cycle; next cycle Flags=0001 and Perform (from IR) = 1.
- Sign extension: MemData=0x1080 -> Imm16=0xFF80; MemData=0x107F -> Imm16=0x007F.
- Counter wrap and clear: preload by 0xFFFF fetches, one more IW -> FetchCnt=0x0000; ClrCnt=1 with IW=1 in the same cycle -> both counters 0.
- Asynchronous reset mid-run: IR=0xF123, Flags=1111; RESET pulsed low between clock edges -> Flags=0, Op=0, Perform=1 before the next edge.
